instruction_loader: RTL and testbench
=====================================

INSTRUCTION_LOADER -- requirements
Module: instruction_loader

Interface
REQ-001 Parameter WORD_SIZE_IN_BYTES, default 4: bytes per instruction word.
REQ-002 Parameter MEM_SIZE_IN_WORDS, default 10: capacity of the downstream instruction memory in words.
REQ-003 i_clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 i_reset  input  1  synchronous, active-low reset.
REQ-005 i_clear  input  1  synchronous restart of a load session without a full reset.
REQ-006 i_byte_valid  input  1  i_byte carries a valid byte this cycle.
REQ-007 i_byte  input  8  incoming program byte, such as from a UART receiver.
REQ-008 o_instruction_write  output  1  one-cycle write strike to the instruction memory.
REQ-009 o_instruction  output  WORD_SIZE_IN_BYTES*8  assembled instruction word.
REQ-010 o_word_count  output  $clog2(MEM_SIZE_IN_WORDS+1)  number of words written in this session.
REQ-011 o_done  output  1  the halt word (all zeros) has been written.
REQ-012 o_error  output  1  memory capacity was exhausted before a halt word arrived.
REQ-013 o_checksum  output  8  running XOR of the accepted bytes (see Configuration).

Function
REQ-014 The FSM SHALL have three states: LOAD, DONE and ERROR.
REQ-015 In LOAD, each cycle with i_byte_valid=1 SHALL accept i_byte into the assembly register and increment the byte index, which is 0..WORD_SIZE_IN_BYTES-1.
REQ-016 Byte order SHALL be big-endian: byte index 0 lands in the most significant byte of the word.
REQ-017 On the edge that accepts the last byte, the byte index SHALL wrap to 0.
REQ-018 On that same edge, o_instruction SHALL take the full word and o_instruction_write SHALL be 1 for exactly the following cycle, giving a latency of 1 cycle from the last byte to the strike.
REQ-019 o_instruction SHALL hold its value until the next word completes.
REQ-020 o_word_count SHALL increment on the same edge that raises o_instruction_write.
REQ-021 A byte presented during a write-strike cycle SHALL be accepted normally, so back-to-back words arrive without a gap.
REQ-022 When the completed word equals 0, the strike SHALL still occur, and the FSM SHALL go to DONE on the same edge.
REQ-023 o_done SHALL be 1 from the strike cycle onward.
REQ-024 When a non-zero word completes and o_word_count becomes MEM_SIZE_IN_WORDS, the FSM SHALL go to ERROR and o_error SHALL be 1 from that point.
REQ-025 The final word SHALL still be written, and no further strikes SHALL occur.
REQ-026 When the halt word is the word that fills memory, DONE SHALL take priority over ERROR.
REQ-027 In DONE and ERROR, i_byte_valid SHALL be ignored; no bytes are accepted and no strikes occur.
REQ-028 i_clear=1 SHALL, on the next edge and in any state, return the FSM to LOAD.
REQ-029 i_clear SHALL zero the byte index, o_word_count, o_done, o_error and o_checksum, and SHALL discard any partial word.
REQ-030 A byte presented in the same cycle as i_clear SHALL be discarded.
REQ-031 If i_clear=1 during a strike cycle, the strike SHALL still complete, and the count SHALL be zero afterwards.

Reset
REQ-032 While i_reset=0 at a rising edge, the FSM SHALL enter LOAD and the byte index SHALL be 0.
REQ-033 Under reset, o_instruction_write=0, o_instruction=0, o_word_count=0, o_done=0, o_error=0 and o_checksum=0.
REQ-034 Reset SHALL take priority over i_clear and i_byte_valid.
REQ-035 A reset in the middle of a word SHALL discard the partial bytes.

Configuration
REQ-036 With macro LOADER_CHECKSUM_EN defined, o_checksum SHALL XOR-accumulate every accepted byte, updated on the accepting edge and cleared by reset and by i_clear.
REQ-037 Without LOADER_CHECKSUM_EN, o_checksum SHALL be constant 0 and no accumulator logic SHALL be generated; all other behaviour is unchanged.

Verification
REQ-038 Normal load: bytes 12,34,56,78 then 00,00,00,00 -> strike with o_instruction=12345678, then a strike with 00000000; o_word_count=2, o_done=1, and the checksum is 08 when the macro is enabled.
REQ-039 Capacity overflow: 10 non-zero words (40 bytes) -> 10 strikes, o_error=1 after the 10th, and an 11th word of bytes produces no strike and leaves the count at 10.
REQ-040 Back-to-back input: i_byte_valid held at 1 for 8 consecutive cycles with bytes AA..B1 -> strikes exactly 1 cycle after the 4th and 8th bytes, with words AAABACAD and AEAFB0B1.
REQ-041 Mid-word recovery: 2 bytes, then i_clear, then DE,AD,BE,EF -> a single strike with DEADBEEF and o_word_count=1.
REQ-042 Reset mid-word: 3 bytes, reset pulsed low for 1 cycle, then 4 bytes 01,02,03,04 -> strike 01020304, and all outputs are 0 during reset.
REQ-043 Post-halt robustness: after DONE, 8 further bytes -> no strike, and o_word_count and o_instruction are unchanged.

Source files
------------

// File: rtl/instruction_loader_if.sv
// Byte-stream and instruction-memory write bundle for instruction_loader.
//
// Handshake: this is a valid-only stream with no backpressure. The loader
// accepts i_byte on every rising edge where i_byte_valid=1 while it is in LOAD
// and i_clear=0; there is no ready signal. o_instruction_write is a one-cycle
// strike. o_instruction is valid while the strike is high and holds its value
// until the next word completes.
interface instruction_loader_if #(
  parameter int WORD_SIZE_IN_BYTES = 4,
  parameter int MEM_SIZE_IN_WORDS  = 10
);
  localparam int CW = $clog2(MEM_SIZE_IN_WORDS + 1);

  logic                              i_clear;
  logic                              i_byte_valid;
  logic [7:0]                        i_byte;
  logic                              o_instruction_write;
  logic [WORD_SIZE_IN_BYTES*8-1:0]   o_instruction;
  logic [CW-1:0]                     o_word_count;
  logic                              o_done;
  logic                              o_error;
  logic [7:0]                        o_checksum;

  // Byte source side (UART receiver, testbench driver).
  modport master (
    output i_clear, i_byte_valid, i_byte,
    input  o_instruction_write, o_instruction, o_word_count,
           o_done, o_error, o_checksum
  );

  // Loader side.
  modport slave (
    input  i_clear, i_byte_valid, i_byte,
    output o_instruction_write, o_instruction, o_word_count,
           o_done, o_error, o_checksum
  );
endinterface

// File: rtl/instruction_loader.sv
// instruction_loader: assembles a byte stream into big-endian instruction
// words and strikes them into an instruction memory, one word per strike.
// A session ends in DONE when the all-zero halt word is written, or in ERROR
// when memory fills with a non-zero word. i_clear restarts a session.
//
// Optional feature: define LOADER_CHECKSUM_EN to enable the running XOR
// checksum of accepted bytes on o_checksum; otherwise o_checksum is tied to 0.
//
// WORD_SIZE_IN_BYTES must be at least 2 (the assembly register holds all but
// the final byte of a word).
module instruction_loader #(
  parameter int WORD_SIZE_IN_BYTES = 4,
  parameter int MEM_SIZE_IN_WORDS  = 10
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  instruction_loader_if.slave  bus,
  output logic [1:0]           o_state
);

  localparam int IW   = WORD_SIZE_IN_BYTES * 8;
  localparam int CW   = $clog2(MEM_SIZE_IN_WORDS + 1);
  localparam int IDXW = (WORD_SIZE_IN_BYTES > 1) ? $clog2(WORD_SIZE_IN_BYTES) : 1;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_DONE  = 2'd1,
    ST_ERROR = 2'd2
  } state_t;

  state_t           state_q;
  state_t           state_d;

  logic [IDXW-1:0]  idx_q;
  logic [IW-9:0]    asm_q;
  logic [IW-1:0]    instr_q;
  logic             write_q;
  logic [CW-1:0]    cnt_q;
  logic [CW-1:0]    cnt_next;

  logic             accept;
  logic             last_byte;
  logic [IW-1:0]    full_word;
  logic             word_zero;
  logic             mem_full;

  // A byte is taken only while loading and never in a clear cycle.
  assign accept    = (state_q == ST_LOAD) && bus.i_byte_valid && !bus.i_clear;
  assign last_byte = accept && (idx_q == IDXW'(WORD_SIZE_IN_BYTES - 1));

  // Earlier bytes sit in asm_q, shifted up as each new byte arrives, so the
  // first byte of a word ends up in the most significant position.
  assign full_word = {asm_q, bus.i_byte};
  assign word_zero = (full_word == '0);
  assign cnt_next  = cnt_q + CW'(1);
  assign mem_full  = (cnt_next == CW'(MEM_SIZE_IN_WORDS));

  // State register; reset dominates everything.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state_q <= ST_LOAD;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: clear restarts the session; halt beats a full memory.
  always_comb begin
    state_d = state_q;
    if (bus.i_clear) begin
      state_d = ST_LOAD;
    end else if (last_byte) begin
      if (word_zero) begin
        state_d = ST_DONE;
      end else if (mem_full) begin
        state_d = ST_ERROR;
      end
    end
  end

  // Status outputs decoded from the current state.
  always_comb begin
    bus.o_done  = (state_q == ST_DONE);
    bus.o_error = (state_q == ST_ERROR);
    o_state     = state_q;
  end

  // Word assembly, write strike and word counter.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      idx_q   <= '0;
      asm_q   <= '0;
      instr_q <= '0;
      write_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      // A strike lasts exactly the cycle after the last byte is taken.
      write_q <= last_byte;
      if (bus.i_clear) begin
        // Drop any partial word; a strike already in flight still shows.
        idx_q <= '0;
        asm_q <= '0;
        cnt_q <= '0;
      end else if (accept) begin
        asm_q <= full_word[IW-9:0];
        if (last_byte) begin
          idx_q   <= '0;
          instr_q <= full_word;
          cnt_q   <= cnt_next;
        end else begin
          idx_q <= idx_q + IDXW'(1);
        end
      end
    end
  end

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] csum_q;

  // Running XOR of every byte taken, restarted by reset and clear.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      csum_q <= 8'h00;
    end else if (bus.i_clear) begin
      csum_q <= 8'h00;
    end else if (accept) begin
      csum_q <= csum_q ^ bus.i_byte;
    end
  end

  assign bus.o_checksum = csum_q;
`else
  assign bus.o_checksum = 8'h00;
`endif

  assign bus.o_instruction_write = write_q;
  assign bus.o_instruction       = instr_q;
  assign bus.o_word_count        = cnt_q;

endmodule

// File: tb/tb_instruction_loader.sv
// Testbench for instruction_loader: a reference model built from byte queues
// predicts each write strike; a monitor pops and compares on every strike.
module tb_instruction_loader;

  localparam int WB  = 4;
  localparam int MEM = 10;
  localparam int IW  = WB * 8;
  localparam int CW  = $clog2(MEM + 1);

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] dbg_state;
  int         cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  instruction_loader_if #(.WORD_SIZE_IN_BYTES(WB), .MEM_SIZE_IN_WORDS(MEM)) bus ();

  instruction_loader #(.WORD_SIZE_IN_BYTES(WB), .MEM_SIZE_IN_WORDS(MEM)) dut (
    .i_clk   (clk),
    .i_reset (rst_n),
    .bus     (bus),
    .o_state (dbg_state)
  );

  // ---------------- reference model state ----------------
  logic [7:0]    part_q[$];
  int            m_count;
  bit            m_done;
  bit            m_err;
  logic [7:0]    m_csum;
  logic [IW-1:0] m_last;

  typedef struct {
    int         cnt;
    bit         done;
    bit         err;
    logic [7:0] cs;
    int         cyc;
  } meta_t;

  logic [IW-1:0] exp_q[$];
  meta_t         meta_q[$];

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_clear();
    part_q.delete();
    m_count = 0;
    m_done  = 0;
    m_err   = 0;
    m_csum  = 8'h00;
  endtask

  // ---------------- driver ----------------
  // Drives one cycle of inputs and advances the model to the state after
  // the edge that will sample them.
  task automatic drive(input bit v, input logic [7:0] b, input bit clr);
    logic [IW-1:0] word;
    @(posedge clk);
    #1;
    bus.i_byte_valid = v;
    bus.i_byte       = b;
    bus.i_clear      = clr;
    if (clr) begin
      model_clear();
    end else if (v && !m_done && !m_err) begin
      part_q.push_back(b);
`ifdef LOADER_CHECKSUM_EN
      m_csum = m_csum ^ b;
`endif
      if (part_q.size() == WB) begin
        word = '0;
        for (int i = 0; i < WB; i++)
          word = word | (IW'(part_q[i]) << (8 * (WB - 1 - i)));
        part_q.delete();
        m_count++;
        m_last = word;
        if (word == '0) m_done = 1;
        else if (m_count == MEM) m_err = 1;
        exp_q.push_back(word);
        meta_q.push_back('{cnt: m_count, done: m_done, err: m_err, cs: m_csum, cyc: cyc + 1});
      end
    end
  endtask

  task automatic send(input logic [7:0] b);
    drive(1'b1, b, 1'b0);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 8'h00, 1'b0);
  endtask

  task automatic clear_session();
    drive(1'b0, 8'h00, 1'b1);
    idle(1);
  endtask

  task automatic do_reset(input bit with_byte);
    @(posedge clk);
    #1;
    rst_n            = 1'b0;
    bus.i_clear      = with_byte;
    bus.i_byte_valid = with_byte;
    bus.i_byte       = 8'h5A;
    model_clear();
    m_last = '0;
    @(posedge clk);
    #1;
    check("rst_write", bus.o_instruction_write, 0);
    check("rst_instr", bus.o_instruction, 0);
    check("rst_count", bus.o_word_count, 0);
    check("rst_done",  bus.o_done, 0);
    check("rst_error", bus.o_error, 0);
    check("rst_csum",  bus.o_checksum, 0);
    rst_n            = 1'b1;
    bus.i_clear      = 1'b0;
    bus.i_byte_valid = 1'b0;
  endtask

  task automatic check_status(input string tag);
    check({tag, "_count"}, bus.o_word_count, m_count);
    check({tag, "_done"},  bus.o_done, m_done);
    check({tag, "_error"}, bus.o_error, m_err);
    check({tag, "_instr"}, bus.o_instruction, m_last);
    check({tag, "_csum"},  bus.o_checksum, m_csum);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (bus.o_instruction_write === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_strike: got word %0h at cycle %0d, expected no strike",
                 bus.o_instruction, cyc);
      end else begin
        logic [IW-1:0] w;
        meta_t         m;
        w = exp_q.pop_front();
        m = meta_q.pop_front();
        check("strike_word",  bus.o_instruction, w);
        check("strike_cycle", cyc, m.cyc);
        check("strike_count", bus.o_word_count, m.cnt);
        check("strike_done",  bus.o_done, m.done);
        check("strike_error", bus.o_error, m.err);
        check("strike_csum",  bus.o_checksum, m.cs);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    bus.i_clear      = 1'b0;
    bus.i_byte_valid = 1'b0;
    bus.i_byte       = 8'h00;
    m_last           = '0;
    model_clear();

    do_reset(1'b1);
    idle(1);

    // Normal load followed by the halt word.
    send(8'h12); send(8'h34); send(8'h56); send(8'h78);
    send(8'h00); send(8'h00); send(8'h00); send(8'h00);
    idle(2);
    check_status("normal");
    check("normal_count_lit", bus.o_word_count, 2);
`ifdef LOADER_CHECKSUM_EN
    check("normal_csum_lit", bus.o_checksum, 8'h08);
`endif

    // Bytes after DONE are ignored.
    for (int i = 0; i < 8; i++) send(8'($urandom_range(1, 255)));
    idle(2);
    check_status("post_halt");

    // Capacity overflow: ten non-zero words, then an eleventh.
    clear_session();
    for (int i = 0; i < 40; i++) send(8'($urandom_range(1, 255)));
    for (int i = 0; i < 4; i++) send(8'($urandom_range(1, 255)));
    idle(2);
    check_status("overflow");
    check("overflow_count_lit", bus.o_word_count, MEM);

    // Mid-word clear, with a byte presented in the clear cycle.
    clear_session();
    send(8'h11); send(8'h22);
    drive(1'b1, 8'h33, 1'b1);
    send(8'hDE); send(8'hAD); send(8'hBE); send(8'hEF);
    idle(2);
    check_status("midclear");
    check("midclear_instr_lit", bus.o_instruction, 32'hDEADBEEF);

    // Back-to-back bytes AA..B1.
    clear_session();
    for (int i = 0; i < 8; i++) send(8'(8'hAA + i));
    idle(2);
    check_status("b2b");

    // Reset in the middle of a word.
    send(8'h77); send(8'h88); send(8'h99);
    do_reset(1'b0);
    send(8'h01); send(8'h02); send(8'h03); send(8'h04);
    idle(2);
    check_status("rst_mid");

    // Halt word is the one that fills memory: DONE wins.
    clear_session();
    for (int i = 0; i < (MEM - 1) * WB; i++) send(8'($urandom_range(1, 255)));
    for (int i = 0; i < WB; i++) send(8'h00);
    idle(2);
    check_status("halt_full");

    // Clear during a strike cycle.
    clear_session();
    send(8'hC0); send(8'hC1); send(8'hC2); send(8'hC3);
    drive(1'b1, 8'hC4, 1'b1);
    idle(2);
    check_status("clear_strike");

    // Randomized phase.
    for (int it = 0; it < 600; it++) begin
      int r;
      r = $urandom_range(0, 99);
      if ((m_done || m_err) && r < 25) begin
        drive(1'b0, 8'h00, 1'b1);
      end else if (r < 2) begin
        drive(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 1'b1);
      end else if (r < 3) begin
        do_reset(1'($urandom_range(0, 1)));
      end else begin
        drive(($urandom_range(0, 3) != 0),
              ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom_range(0, 255)),
              1'b0);
      end
      if (it % 50 == 49) begin
        idle(1);
        check_status("rand");
      end
    end

    idle(3);
    check("scoreboard_drain", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
